scan_display_f: RTL and testbench
=================================

// Module: scan_display_f
// PURPOSE
//  Time-multiplexed 4-digit 7-segment driver; consumes the n_3..n_0 digit codes from the
//  frequency-label decoder (Deco_f) and drives the board's shared segment bus and anodes.
//  Latches a full 4-digit snapshot once per scan frame so a mid-frame code change never tears.
//  Sits between the decoder and the board display pins.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles each digit is lit (100 MHz -> 2 kHz digit, 500 Hz frame)
//  CNT_W        16     prescaler width; must satisfy 2**CNT_W >= REFRESH_DIV
// PORTS
//  clk         in   1  system clock; all flops rise on this edge
//  rst_n       in   1  asynchronous reset, active low
//  n_3         in   1  digit 3 code (leftmost), 0..1
//  n_2         in   3  digit 2 code, 0..7
//  n_1         in   4  digit 1 code, 0..15 (10 = decimal point)
//  n_0         in   3  digit 0 code (rightmost), 0..7
//  an          out  4  anode enables, active low; an[k] selects digit k
//  seg         out  8  {dp,g,f,e,d,c,b,a}, active low
//  frame_tick  out  1  1-cycle pulse when a new snapshot is captured
// BEHAVIOUR
//  - Reset (rst_n=0, async, effective immediately, incl. mid-frame): an=4'b1111, seg=8'hFF,
//    frame_tick=0, prescaler=0, digit index=3, snapshot regs=0.
//  - Prescaler counts 0..REFRESH_DIV-1 then wraps to 0; tick = (cnt==REFRESH_DIV-1).
//  - On tick: idx <= idx+1 (2-bit wrap 3->0). When idx==3 at tick (wrap to 0):
//    snapshot <= {n_3,n_2,n_1,n_0}; frame_tick=1 next cycle; digit 0 is rendered from the
//    inputs sampled that same cycle (not the stale snapshot).
//  - First tick after reset release (REFRESH_DIV cycles) is therefore a capture tick.
//  - an/seg/frame_tick all registered; update the cycle after tick; held steady between ticks.
//  - an = ~(4'b0001 << idx); never more than one anode active; no blank gap between digits.
//  - Digit k renders snapshot code k, zero-extended to 4 bits:
//    0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 10:7F (dp only) 11..15:FF (blank).
//  - Input-to-display latency: 1..4*REFRESH_DIV+1 cycles; inputs need no stability between
//    capture ticks.
//  - No other state; no handshake to Deco_f (inputs are level, combinational from decoder).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: leading-zero suppression at render time from the snapshot:
//    digit3 blank if n_3==0; digit2 blank if also n_2==0; digit1 blank if also n_1==0;
//    digit0 never blanked; code 10 counts as non-zero. Blanked digit: anode still cycles,
//    seg=8'hFF.
//  Not defined: every digit rendered per table (zeros shown as C0).
// TESTING  (REFRESH_DIV=4 in all benches)
//  1 Hold rst_n=0 -> an=1111, seg=FF, frame_tick=0; release -> frame_tick pulses at cycle 5,
//    then every 16 cycles.
//  2 Inputs {1,2,10,5} -> per 4 cycles: an=1110/seg=92, 1101/7F, 1011/A4, 0111/F9, repeat.
//  3 Inputs {0,1,10,5}, switch to {0,2,0,0} while idx=2 -> digits 2,3 keep old (F9,C0)
//    until next frame_tick, then 0,0,2,0 -> C0,C0,A4,C0.
//  4 Inputs {0,0,2,5}: with LEADING_ZERO_BLANK_EN -> digits 3,2 seg=FF, digit1=A4,
//    digit0=92; without -> C0,C0,A4,92.
//  5 n_1 swept 11..15 -> digit1 seg=FF each frame; digits 0,2,3 unaffected.
//  6 Assert rst_n mid-digit 2 for 1 ns -> an=1111/seg=FF without a clock edge; after
//    release, capture at cycle 4 and scan restarts at digit 0.

Source files
------------

// File: rtl/scan_display_f.sv
// ============================================================================
// Module      : scan_display_f
// Description : Time-multiplexed 4-digit 7-segment driver. Takes a coherent
//               snapshot of the decoder's digit codes once per scan frame and
//               drives the shared active-low segment bus and anode enables.
//               Optional build macro LEADING_ZERO_BLANK_EN turns on
//               leading-zero suppression, computed from the snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_display_f #(
    parameter int REFRESH_DIV = 50000,  // clk cycles each digit stays lit
    parameter int CNT_W       = 16      // prescaler width, 2**CNT_W >= REFRESH_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       n_3,
    input  logic [2:0] n_2,
    input  logic [3:0] n_1,
    input  logic [2:0] n_0,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       frame_tick
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_snap_n3;
    logic [2:0]       r_snap_n2;
    logic [3:0]       r_snap_n1;
    logic [3:0]       r_an;
    logic [7:0]       r_seg;
    logic             r_frame_tick;

    logic             w_tick;
    logic             w_capture;
    logic [1:0]       w_idx_next;
    logic [3:0]       w_code;
    logic             w_blank;
    logic [7:0]       w_seg_next;
    logic [3:0]       w_an_next;

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one digit code; 11..15 blank.
    function automatic logic [7:0] seg_lut(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            4'd10:   pat = 8'h7F;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    // Select the digit that becomes visible after this tick and build its drive.
    // Digit 0 is only ever shown starting on the capture tick, so it is taken
    // straight from the live input that the snapshot captures in that same
    // cycle; that is why digit 0 needs no snapshot register of its own.
    always_comb begin
        w_tick     = (r_cnt == c_CNT_LAST);
        w_capture  = w_tick && (r_idx == 2'd3);
        w_idx_next = r_idx + 2'd1;
        w_code     = {1'b0, n_0};
        w_blank    = 1'b0;
        case (w_idx_next)
            2'd0:    w_code = {1'b0, n_0};
            2'd1:    w_code = r_snap_n1;
            2'd2:    w_code = {1'b0, r_snap_n2};
            default: w_code = {3'b000, r_snap_n3};
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero only if it and every digit to its left
        // are zero; code 10 (decimal point) counts as non-zero.
        case (w_idx_next)
            2'd3:    w_blank = (r_snap_n3 == 1'b0);
            2'd2:    w_blank = (r_snap_n3 == 1'b0) && (r_snap_n2 == 3'd0);
            2'd1:    w_blank = (r_snap_n3 == 1'b0) && (r_snap_n2 == 3'd0)
                               && (r_snap_n1 == 4'd0);
            default: w_blank = 1'b0;
        endcase
`endif
        w_seg_next = w_blank ? 8'hFF : seg_lut(w_code);
        w_an_next  = ~(4'b0001 << w_idx_next);
    end

    // Prescaler: one digit slot every REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Digit index and frame snapshot; index starts at 3 so the first tick captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= 2'd3;
            r_snap_n3 <= 1'b0;
            r_snap_n2 <= 3'd0;
            r_snap_n1 <= 4'd0;
        end else if (w_tick) begin
            r_idx <= w_idx_next;
            if (w_capture) begin
                r_snap_n3 <= n_3;
                r_snap_n2 <= n_2;
                r_snap_n1 <= n_1;
            end
        end
    end

    // Registered display drive; held steady between ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= 4'b1111;
            r_seg        <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_capture;
            if (w_tick) begin
                r_an  <= w_an_next;
                r_seg <= w_seg_next;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_scan_display_f.sv
// ============================================================================
// Module      : tb_scan_display_f
// Description : Directed self-checking bench for scan_display_f with
//               REFRESH_DIV=4. Expected values are hand-computed; the
//               LEADING_ZERO_BLANK_EN macro selects the blanked expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_display_f;

    logic       clk;
    logic       rst_n;
    logic       n_3;
    logic [2:0] n_2;
    logic [3:0] n_1;
    logic [2:0] n_0;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_tick;

    int n_checks;
    int n_fails;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit c_LZB = 1'b1;
`else
    localparam bit c_LZB = 1'b0;
`endif

    scan_display_f #(
        .REFRESH_DIV (4),
        .CNT_W       (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .n_3        (n_3),
        .n_2        (n_2),
        .n_1        (n_1),
        .n_0        (n_0),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison of the three outputs against expected values.
    task automatic check_out(input string tag, input logic [3:0] exp_an,
                             input logic [7:0] exp_seg, input logic exp_ft);
        n_checks++;
        assert (an === exp_an) else begin
            n_fails++;
            $error("FAIL %s an: observed %b expected %b", tag, an, exp_an);
        end
        n_checks++;
        assert (seg === exp_seg) else begin
            n_fails++;
            $error("FAIL %s seg: observed %h expected %h", tag, seg, exp_seg);
        end
        n_checks++;
        assert (frame_tick === exp_ft) else begin
            n_fails++;
            $error("FAIL %s frame_tick: observed %b expected %b", tag, frame_tick, exp_ft);
        end
    endtask

    // Advance n falling edges, then check that digit idx is lit with exp_seg.
    task automatic run_digit(input int n, input string tag, input int idx,
                             input logic [7:0] exp_seg, input logic exp_ft);
        logic [3:0] one_hot;
        repeat (n) @(negedge clk);
        one_hot = 4'b0001 << idx;
        check_out(tag, ~one_hot, exp_seg, exp_ft);
    endtask

    // A full frame: digit 0 (with frame_tick) through digit 3.
    task automatic run_frame(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        run_digit(4, {tag, "_d0"}, 0, d0, 1'b1);
        run_digit(4, {tag, "_d1"}, 1, d1, 1'b0);
        run_digit(4, {tag, "_d2"}, 2, d2, 1'b0);
        run_digit(4, {tag, "_d3"}, 3, d3, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        {n_3, n_2, n_1, n_0} = {1'b1, 3'd2, 4'd10, 3'd5};

        // Reset hold and first capture timing.
        repeat (3) @(negedge clk);
        check_out("reset_hold", 4'b1111, 8'hFF, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_out("pre_first_tick", 4'b1111, 8'hFF, 1'b0);
        run_digit(1, "first_capture", 0, 8'h92, 1'b1);
        run_digit(1, "pulse_one_cycle", 0, 8'h92, 1'b0);
        repeat (2) @(negedge clk);
        run_digit(1, "f1_d1", 1, 8'h7F, 1'b0);
        run_digit(4, "f1_d2", 2, 8'hA4, 1'b0);
        run_digit(4, "f1_d3", 3, 8'hF9, 1'b0);
        run_frame("f2", 8'h92, 8'h7F, 8'hA4, 8'hF9);

        // Mid-frame input change must not tear the frame.
        {n_3, n_2, n_1, n_0} = {1'b0, 3'd1, 4'd10, 3'd5};
        run_frame("tear_a", 8'h92, 8'h7F, 8'hF9, c_LZB ? 8'hFF : 8'hC0);
        run_digit(4, "tear_b_d0", 0, 8'h92, 1'b1);
        run_digit(4, "tear_b_d1", 1, 8'h7F, 1'b0);
        run_digit(4, "tear_b_d2", 2, 8'hF9, 1'b0);
        {n_3, n_2, n_1, n_0} = {1'b0, 3'd2, 4'd0, 3'd0};
        run_digit(4, "tear_b_d3", 3, c_LZB ? 8'hFF : 8'hC0, 1'b0);
        run_frame("tear_c", 8'hC0, 8'hC0, 8'hA4, c_LZB ? 8'hFF : 8'hC0);

        // Leading zeros.
        {n_3, n_2, n_1, n_0} = {1'b0, 3'd0, 4'd2, 3'd5};
        run_frame("lz_0025", 8'h92, 8'hA4, c_LZB ? 8'hFF : 8'hC0, c_LZB ? 8'hFF : 8'hC0);
        {n_3, n_2, n_1, n_0} = {1'b0, 3'd0, 4'd0, 3'd3};
        run_frame("lz_0003", 8'hB0, c_LZB ? 8'hFF : 8'hC0, c_LZB ? 8'hFF : 8'hC0,
                  c_LZB ? 8'hFF : 8'hC0);
        {n_3, n_2, n_1, n_0} = {1'b0, 3'd0, 4'd10, 3'd4};
        run_frame("lz_00dp4", 8'h99, 8'h7F, c_LZB ? 8'hFF : 8'hC0, c_LZB ? 8'hFF : 8'hC0);

        // Remaining code table entries.
        {n_3, n_2, n_1, n_0} = {1'b1, 3'd3, 4'd9, 3'd0};
        run_frame("codes_1390", 8'hC0, 8'h90, 8'hB0, 8'hF9);
        {n_3, n_2, n_1, n_0} = {1'b0, 3'd4, 4'd8, 3'd6};
        run_frame("codes_0486", 8'h82, 8'h80, 8'h99, c_LZB ? 8'hFF : 8'hC0);
        {n_3, n_2, n_1, n_0} = {1'b1, 3'd7, 4'd7, 3'd1};
        run_frame("codes_1771", 8'hF9, 8'hF8, 8'hF8, 8'hF9);

        // Blank codes 11..15 on digit 1.
        {n_3, n_2, n_0} = {1'b1, 3'd6, 3'd7};
        for (int v = 11; v <= 15; v++) begin
            n_1 = 4'(v);
            run_frame($sformatf("blank_%0d", v), 8'hF8, 8'hFF, 8'h82, 8'hF9);
        end

        // Asynchronous reset in the middle of digit 2.
        {n_3, n_2, n_1, n_0} = {1'b1, 3'd2, 4'd10, 3'd5};
        run_frame("pre_rst", 8'h92, 8'h7F, 8'hA4, 8'hF9);
        run_digit(4, "pre_rst2_d0", 0, 8'h92, 1'b1);
        run_digit(4, "pre_rst2_d1", 1, 8'h7F, 1'b0);
        run_digit(4, "pre_rst2_d2", 2, 8'hA4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 4'b1111, 8'hFF, 1'b0);
        #1;
        rst_n = 1'b1;
        {n_3, n_2, n_1, n_0} = {1'b0, 3'd5, 4'd4, 3'd2};
        repeat (3) @(negedge clk);
        check_out("post_rst_wait", 4'b1111, 8'hFF, 1'b0);
        run_digit(1, "post_rst_d0", 0, 8'hA4, 1'b1);
        run_digit(4, "post_rst_d1", 1, 8'h99, 1'b0);
        run_digit(4, "post_rst_d2", 2, 8'h92, 1'b0);
        run_digit(4, "post_rst_d3", 3, c_LZB ? 8'hFF : 8'hC0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
